// File: rtl/matmul_rr_scheduler.sv
// matmul_rr_scheduler
//   Shares one sequential 2x2 signed matrix multiplier among NREQ requesters.
//   Pending requests are arbitrated round-robin. The winner's operands are
//   latched and the multiplier gets a one-cycle start pulse. Its result is then
//   returned tagged with the requester id. If the multiplier never completes,
//   a watchdog produces an error response.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot
//   req_a/req_b         operands per requester, slice i = {x11,x12,x21,x22}, 4b signed
//   mm_start            one-cycle start pulse to the multiplier
//   mm_a/mm_b           latched operands, stable from grant until the response is accepted
//   mm_done/mm_c        multiplier completion pulse and result {c11,c12,c21,c22}, 9b signed
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_c/rsp_err response payload; rsp_err=1 means watchdog timeout with rsp_c=0
//   busy                high while a job is in flight (state != IDLE)
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer that raises valid holds it
// and its payload stable until that transfer. Ready may depend combinationally
// on valid. Here req_ready is combinational and is only asserted in IDLE.
// rsp_valid is registered and its payload is held until rsp_ready.

module matmul_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              mm_start,
  output logic [15:0]       mm_a,
  output logic [15:0]       mm_b,
  input  logic              mm_done,
  input  logic [35:0]       mm_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [35:0]       rsp_c,
  output logic              rsp_err,
  output logic              busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] job_id;
  logic [WDW-1:0] wd;

  // Arbitration: rotate the request vector so rr_ptr sits at bit 0. The lowest
  // set bit of the rotated vector is then the round-robin winner. Its offset
  // is added back to rr_ptr modulo NREQ.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    win_id;
  logic [NREQ-1:0]   grant;
  logic [15:0]       win_a;
  logic [15:0]       win_b;

  always_comb begin
    dbl   = {req_valid, req_valid};
    rot   = NREQ'(dbl >> rr_ptr);
    found = 1'b0;
    sum   = '0;
    // Descending scan: the last hit, i.e. the lowest offset, wins.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (IDW+1)'(j);
      end
    end
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    win_id = sum[IDW-1:0];
    grant  = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (win_id == IDW'(i))) begin
        grant[i] = 1'b1;
        win_a    = req_a[i*16 +: 16];
        win_b    = req_b[i*16 +: 16];
      end
    end
  end

  // Grants are offered only in IDLE. While reset is held, the grant is forced
  // low so that every output reads 0.
  assign req_ready = ((state == S_IDLE) && rst_n) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      job_id    <= '0;
      wd        <= '0;
      mm_start  <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // mm_done is deliberately ignored here; a stale pulse has no job.
          if (found) begin
            mm_a     <= win_a;
            mm_b     <= win_b;
            job_id   <= win_id;
            mm_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          mm_start <= 1'b0;
          wd       <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (mm_done) begin
            rsp_c     <= mm_c;
            rsp_err   <= 1'b0;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (wd == WD_LAST) begin
            rsp_c     <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= job_id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
